// File: rtl/wb_master_bridge_pkg.sv
// Shared types and bus widths for the Wishbone master bridge.
package wb_master_bridge_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/wb_master_timer.sv
// Saturating bus-cycle counter for the Wishbone master bridge. Clear has
// priority over enable; expired is high while the count equals TIMEOUT.
// Only instantiated when WB_MASTER_BRIDGE_TIMEOUT_EN is defined.
module wb_master_timer
  import wb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic-cycle initiator. Each accepted command
// becomes one Wishbone read or write; the result is returned on the response
// stream. Optional bus timeout: define WB_MASTER_BRIDGE_TIMEOUT_EN.
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  if ((TIMEOUT == 0) || (TIMEOUT > 65535)) begin : gen_timeout_range_check
    $error("wb_master_bridge: TIMEOUT must be in 1..65535");
  end

  state_e state_q, state_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                timeout_hit;

  // cmd_ready is a registered copy of "next state is idle" so it stays low
  // through reset and rises the cycle after reset is released.
  assign accept = (state_q == StIdle) && cmd_ready_q && cmd_valid;

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
  logic timer_expired;

  wb_master_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (state_q == StBus),
    .expired (timer_expired)
  );

  assign timeout_hit = (state_q == StBus) && timer_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack is checked first so it wins over a simultaneous expiry.
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = StResp;
        end else if (timeout_hit) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge. Expected responses are pushed to
// a scoreboard queue when a command is driven and popped at the response.
module tb_wb_master_bridge;

  localparam int unsigned TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   accept_cycle = 0;

  wb_master_bridge #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // One full transaction, entered and left just after a falling edge.
  // ack_at < 0 means the target never acks; bus_cycles is how long cyc must
  // stay high; hold is the number of cycles rsp_ready is withheld.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int ack_at, input int bus_cycles,
                     input logic [31:0] rdata, input int hold);
    rsp_t        e;
    logic [31:0] held_dat;
    logic        held_err;
    int          guard;
    int          bus_bad;
    e.err = (ack_at < 0);
    e.dat = (we || e.err) ? 32'h0 : rdata;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
      cmd_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    accept_cycle = cyc_cnt;
    bus_bad = 0;
    for (int i = 0; i < bus_cycles; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
      if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== we ||
          wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        if (bus_bad == 0)
          $display("FAIL bus_hold cycle %0d: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b rv=%b, required 1 1 %b %h %h %h 0 0",
                   i, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
                   cmd_ready, rsp_valid, we, adr, dat, sel);
        bus_bad++;
      end
      if (i == ack_at) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rdata;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
      end
    end
    checks++;
    if (bus_bad != 0) failures++;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_rise: cyc=%b stb=%b rsp_valid=%b, required 0 0 1",
               wbm_cyc_o, wbm_stb_o, rsp_valid);
    end
    held_dat = rsp_dat;
    held_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      // Stray acks while waiting in RESP must be ignored.
      wbm_ack_i = i[0];
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_err !== held_err ||
          cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
        failures++;
        $display("FAIL rsp_hold cycle %0d: rv=%b dat=%h err=%b rdy=%b cyc=%b, required 1 %h %b 0 0",
                 i, rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o, held_dat, held_err);
      end
    end
    wbm_ack_i = 1'b0;
    e = sb.pop_front();
    checks++;
    if (rsp_dat !== e.dat || rsp_err !== e.err) begin
      failures++;
      $display("FAIL rsp_data: dat=%h err=%b, required dat=%h err=%b",
               rsp_dat, rsp_err, e.dat, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL rsp_done: rv=%b rdy=%b cyc=%b, required 0 1 0",
               rsp_valid, cmd_ready, wbm_cyc_o);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0 ||
        wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 ||
        wbm_sel_o !== 4'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b rv=%b err=%b dat=%h cyc=%b stb=%b we=%b sel=%h adr=%h wdat=%h, required all 0",
               cmd_ready, rsp_valid, rsp_err, rsp_dat, wbm_cyc_o, wbm_stb_o, wbm_we_o,
               wbm_sel_o, wbm_adr_o, wbm_dat_o);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_zero_wait();
    txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'hA5A5_A5A5, 0);
  endtask

  task automatic test_read_wait();
    txn(1'b0, 32'h3000_0010, 32'h0BAD_F00D, 4'h3, 5, 6, 32'h1234_5678, 0);
  endtask

  task automatic test_backpressure();
    txn(1'b0, 32'h3000_0020, 32'h0, 4'hC, 1, 2, 32'h8765_4321, 10);
    txn(1'b1, 32'h3000_0024, 32'h0000_00FF, 4'h1, 0, 1, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int first;
    txn(1'b1, 32'h3000_0100, 32'h1111_2222, 4'hF, 0, 1, 32'h0, 0);
    first = accept_cycle;
    txn(1'b0, 32'h3000_0104, 32'h0, 4'hF, 0, 1, 32'h5555_AAAA, 0);
    checks++;
    if (accept_cycle - first != 3) begin
      failures++;
      $display("FAIL back_to_back_spacing: %0d cycles, required 3", accept_cycle - first);
    end
  endtask

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, -1, TIMEOUT + 1, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h3000_0204, 32'h0, 4'hF, TIMEOUT, TIMEOUT + 1, 32'hCAFE_F00D, 0);
  endtask
`else
  task automatic test_no_timeout();
    txn(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1000, 1001, 32'h7777_1234, 0);
  endtask
`endif

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0400;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_bus: cyc=%b stb=%b rv=%b rdy=%b, required 0 0 0 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_bus_idle: rdy=%b rv=%b cyc=%b, required 1 0 0",
               cmd_ready, rsp_valid, wbm_cyc_o);
    end
    txn(1'b0, 32'h3000_0408, 32'h0, 4'h6, 2, 3, 32'h2468_ACE0, 0);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_backpressure();
    test_back_to_back();
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_bus();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
